// File: rtl/julia_scheduler.sv
// -----------------------------------------------------------------------------
// julia_scheduler
//   Frame-level controller for a bank of NUM_JULIA Julia worker blocks.
//   - Hands out one pixel job per cycle to an idle worker, round-robin, with an
//     incrementing pixel address starting at BASE_ADDR.
//   - Collects finished results (round-robin among done workers) into a single
//     registered valid/ready write port, acknowledging each captured worker.
//   - Pulses frame_done once every pixel has been issued, collected and written.
//
// Optional build macro: JULIA_SCHED_PERF_EN
//   When defined, adds stall_cycles[31:0], a saturating count of cycles with
//   wr_valid && !wr_ready. It clears on rst and on an accepted frame_start.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   frame_start       pulse, starts a frame when idle (ignored otherwise)
//   frame_busy        high while a frame is in progress
//   frame_done        one-cycle pulse when the frame completes
//   job_start         one-hot start pulse to a worker
//   job_addr          pixel address belonging to job_start
//   done              per-worker result ready, held until ack
//   cataddresses      worker i result address at [32i+31:32i]
//   catpixels         worker i result pixel at [8i+7:8i]
//   ack               one-hot, one-cycle result acknowledge
//   wr_valid/wr_ready write handshake toward the frame-buffer writer
//   wr_addr, wr_data  write address and pixel
// -----------------------------------------------------------------------------
module julia_scheduler #(
    parameter int NUM_JULIA    = 8,
    parameter int ADDR_W       = 32,
    parameter int FRAME_PIXELS = 307200,
    parameter int BASE_ADDR    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    output logic                    frame_busy,
    output logic                    frame_done,
    output logic [NUM_JULIA-1:0]    job_start,
    output logic [ADDR_W-1:0]       job_addr,
    input  logic [NUM_JULIA-1:0]    done,
    input  logic [NUM_JULIA*32-1:0] cataddresses,
    input  logic [NUM_JULIA*8-1:0]  catpixels,
    output logic [NUM_JULIA-1:0]    ack,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [7:0]              wr_data
`ifdef JULIA_SCHED_PERF_EN
    ,
    output logic [31:0]             stall_cycles
`endif
);

    localparam int PTR_W = (NUM_JULIA > 1) ? $clog2(NUM_JULIA) : 1;
    localparam logic [NUM_JULIA-1:0] ONE_S = {{(NUM_JULIA-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic [NUM_JULIA-1:0] busy_q, busy_d;
    logic [PTR_W-1:0]     disp_ptr_q, disp_ptr_d;
    logic [PTR_W-1:0]     coll_ptr_q, coll_ptr_d;
    logic [NUM_JULIA-1:0] job_start_q, job_start_d;
    logic [ADDR_W-1:0]    job_addr_q, job_addr_d;
    logic [NUM_JULIA-1:0] ack_q, ack_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic                 frame_busy_q, frame_busy_d;
    logic                 frame_done_q, frame_done_d;

    logic [PTR_W:0]       disp_pick_s;   // {found, index}
    logic [PTR_W:0]       coll_pick_s;   // {found, index}
    logic [NUM_JULIA-1:0] disp_oh_s;
    logic [NUM_JULIA-1:0] coll_oh_s;
    logic [31:0]          cap_addr_s;
    logic [7:0]           cap_pix_s;
    logic                 last_s;
    logic                 load_s;

    // First set bit of mask at or after ptr, wrapping; returns {found, index}.
    // Scanning from the far end keeps the nearest hit as the final assignment.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_JULIA-1:0] mask,
                                               input logic [PTR_W-1:0]     ptr);
        logic [PTR_W:0]   res;
        logic [PTR_W-1:0] idx;
        res = '0;
        for (int k = NUM_JULIA - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_JULIA);
            res = mask[idx] ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    // Next-state: frame FSM, dispatch and result collection.
    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        busy_d       = busy_q;
        disp_ptr_d   = disp_ptr_q;
        coll_ptr_d   = coll_ptr_q;
        job_start_d  = '0;
        job_addr_d   = job_addr_q;
        ack_d        = '0;
        wr_valid_d   = wr_valid_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;

        // A worker still holding done is neither re-dispatched nor re-captured.
        disp_pick_s = rr_pick(~busy_q & ~done, disp_ptr_q);
        coll_pick_s = rr_pick(done & busy_q, coll_ptr_q);
        disp_oh_s   = ONE_S << disp_pick_s[PTR_W-1:0];
        coll_oh_s   = ONE_S << coll_pick_s[PTR_W-1:0];
        last_s      = (issue_cnt_q == ADDR_W'(FRAME_PIXELS));
        load_s      = !wr_valid_q || wr_ready;

        cap_addr_s = 32'd0;
        cap_pix_s  = 8'd0;
        for (int i = 0; i < NUM_JULIA; i++) begin
            cap_addr_s = (coll_pick_s[PTR_W-1:0] == PTR_W'(i)) ? cataddresses[32*i +: 32] : cap_addr_s;
            cap_pix_s  = (coll_pick_s[PTR_W-1:0] == PTR_W'(i)) ? catpixels[8*i +: 8]      : cap_pix_s;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d     = ST_RUN;
                    issue_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_d = ST_DRAIN;
                end else if (disp_pick_s[PTR_W]) begin
                    job_start_d = disp_oh_s;
                    job_addr_d  = ADDR_W'(BASE_ADDR) + issue_cnt_q;
                    busy_d      = busy_q | disp_oh_s;
                    issue_cnt_d = issue_cnt_q + ADDR_W'(1'b1);
                    disp_ptr_d  = PTR_W'((int'(disp_pick_s[PTR_W-1:0]) + 1) % NUM_JULIA);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((busy_q == '0) && !wr_valid_q) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output register refills when empty or being accepted this edge,
        // which gives back-to-back writes with no bubble.
        if (load_s) begin
            if (coll_pick_s[PTR_W]) begin
                wr_valid_d = 1'b1;
                wr_addr_d  = ADDR_W'(cap_addr_s);
                wr_data_d  = cap_pix_s;
                ack_d      = coll_oh_s;
                busy_d     = busy_d & ~coll_oh_s;
                coll_ptr_d = PTR_W'((int'(coll_pick_s[PTR_W-1:0]) + 1) % NUM_JULIA);
            end else begin
                wr_valid_d = 1'b0;
            end
        end else begin
            wr_valid_d = wr_valid_q;
        end

        frame_busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            issue_cnt_q  <= '0;
            busy_q       <= '0;
            disp_ptr_q   <= '0;
            coll_ptr_q   <= '0;
            job_start_q  <= '0;
            job_addr_q   <= '0;
            ack_q        <= '0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'd0;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            busy_q       <= busy_d;
            disp_ptr_q   <= disp_ptr_d;
            coll_ptr_q   <= coll_ptr_d;
            job_start_q  <= job_start_d;
            job_addr_q   <= job_addr_d;
            ack_q        <= ack_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_busy_q <= frame_busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_busy = frame_busy_q;
    assign frame_done = frame_done_q;
    assign job_start  = job_start_q;
    assign job_addr   = job_addr_q;
    assign ack        = ack_q;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

`ifdef JULIA_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Saturating backpressure counter, restarted by an accepted frame_start.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_IDLE) && frame_start) begin
            stall_d = 32'd0;
        end else if (wr_valid_q && !wr_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Backpressure counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
